// File: rtl/mant_div_if.sv
// rtl/mant_div_if.sv - operand/result handshake bundle for the 24-bit mantissa divider
interface mant_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] q;
  logic [23:0] r;
  logic        dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, dz
  );
endinterface

// File: rtl/mant_div.sv
// rtl/mant_div.sv - 24-bit radix-2 restoring divider, IDLE/BUSY/DONE handshake FSM
// Optional MANT_DIV_DZ_FAST_EN: divide-by-zero skips the iteration loop.
module mant_div (
  input logic       clk,
  input logic       rst_n,
  mant_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [23:0] rem;
  logic [23:0] dvd;
  logic [23:0] dvs;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [23:0] q_q;
  logic [23:0] r_q;
  logic        dz_q;

  logic [24:0] pr;
  logic        ge;
  logic [23:0] rem_nxt;

  // When ge is set the difference is below dvs, so 24-bit wraparound keeps it exact.
  always_comb begin
    pr      = {rem, dvd[23]};
    ge      = (pr >= {1'b0, dvs});
    rem_nxt = ge ? (pr[23:0] - dvs) : pr[23:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      rem         <= 24'd0;
      dvd         <= 24'd0;
      dvs         <= 24'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= 24'd0;
      r_q         <= 24'd0;
      dz_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd        <= bus.a;
            dvs        <= bus.b;
            rem        <= 24'd0;
            cnt        <= 5'd0;
            in_ready_q <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
`ifdef MANT_DIV_DZ_FAST_EN
          if (dvs == 24'd0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            q_q         <= 24'hFFFFFF;
            r_q         <= dvd;
            dz_q        <= 1'b1;
          end else begin
`else
          begin
`endif
            // Quotient bits shift into dvd from the bottom as dividend bits leave the top.
            rem <= rem_nxt;
            dvd <= {dvd[22:0], ge};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd23) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              q_q         <= {dvd[22:0], ge};
              r_q         <= rem_nxt;
              dz_q        <= (dvs == 24'd0);
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_mant_div.sv
// tb/tb_mant_div.sv - self-checking bench for mant_div against an arithmetic reference
module tb_mant_div;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mant_div_if bus ();

  mant_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_q(input logic [23:0] a_i, input logic [23:0] b_i);
    return (b_i == 24'd0) ? 24'hFFFFFF : a_i / b_i;
  endfunction

  function automatic logic [23:0] ref_r(input logic [23:0] a_i, input logic [23:0] b_i);
    return (b_i == 24'd0) ? a_i : a_i % b_i;
  endfunction

  function automatic int ref_lat(input logic [23:0] b_i);
`ifdef MANT_DIV_DZ_FAST_EN
    if (b_i == 24'd0) return 1;
`endif
    return 24;
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", 48'(bus.in_ready), 48'd1);
  endtask

  task automatic accept(input logic [23:0] a_i, input logic [23:0] b_i);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.a        = a_i;
    bus.b        = b_i;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 24'($urandom);
    bus.b        = 24'($urandom);
  endtask

  task automatic run_op(input logic [23:0] a_i, input logic [23:0] b_i, input int hold, input bit poke);
    int k;
    logic [23:0] eq, er;
    eq = ref_q(a_i, b_i);
    er = ref_r(a_i, b_i);
    accept(a_i, b_i);
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("latency", 48'(k), 48'(ref_lat(b_i)));
    check("q", 48'(bus.q), 48'(eq));
    check("r", 48'(bus.r), 48'(er));
    check("dz", 48'(bus.dz), 48'(b_i == 24'd0));
    if (b_i != 24'd0) begin
      check("identity", 48'(bus.q) * 48'(b_i) + 48'(bus.r), 48'(a_i));
      check("r_lt_b", 48'(bus.r < b_i), 48'd1);
    end
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.a        = 24'($urandom);
        bus.b        = 24'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 48'(bus.out_valid), 48'd1);
      check("hold_q", 48'(bus.q), 48'(eq));
      check("hold_r", 48'(bus.r), 48'(er));
      check("hold_in_ready", 48'(bus.in_ready), 48'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("handoff_valid", 48'(bus.out_valid), 48'd0);
    check("handoff_in_ready", 48'(bus.in_ready), 48'd1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [23:0] ra, rb;
    int sel;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 24'd0;
    bus.b         = 24'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 48'(bus.in_ready), 48'd1);
    check("rst_out_valid", 48'(bus.out_valid), 48'd0);
    check("rst_q", 48'(bus.q), 48'd0);
    check("rst_r", 48'(bus.r), 48'd0);
    check("rst_dz", 48'(bus.dz), 48'd0);

    run_op(24'd100, 24'd7, 0, 1'b0);
    run_op(24'hFFFFFF, 24'd1, 0, 1'b0);
    run_op(24'd3, 24'd10, 0, 1'b0);
    run_op(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0);
    run_op(24'd5, 24'd0, 0, 1'b0);
    run_op(24'd1000, 24'd33, 10, 1'b1);

    // Reset in the middle of an iteration run must discard the pending result.
    accept(24'd500, 24'd9);
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_out_valid", 48'(bus.out_valid), 48'd0);
    check("abort_q", 48'(bus.q), 48'd0);
    check("abort_r", 48'(bus.r), 48'd0);
    check("abort_in_ready", 48'(bus.in_ready), 48'd1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_result", 48'(seen), 48'd0);
    run_op(24'd500, 24'd9, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      sel = int'($urandom_range(0, 9));
      ra  = (sel == 9) ? 24'($urandom_range(0, 255)) : 24'($urandom);
      case (sel)
        0:       rb = 24'd0;
        1:       rb = 24'd1;
        2, 3, 4: rb = 24'($urandom_range(1, 255));
        default: rb = 24'($urandom);
      endcase
      run_op(ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
